// File: rtl/rob_pkg.sv
// Shared sizing defaults and entry/index types for the two-wide reorder buffer.
package rob_pkg;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int PC_W   = 8;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef logic [IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Two-wide in-order reorder buffer: allocates up to two renamed instructions per
// cycle, records out-of-order completions, retires up to two per cycle in order.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = rob_pkg::DEPTH,
  parameter int PREG_W = rob_pkg::PREG_W,
  parameter int PC_W   = rob_pkg::PC_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid1,
  input  logic              valid2,
  input  logic [PC_W-1:0]   pc1,
  input  logic [PC_W-1:0]   pc2,
  input  logic [PREG_W-1:0] pd1,
  input  logic [PREG_W-1:0] pd2,
  input  logic [PREG_W-1:0] old_pd1,
  input  logic [PREG_W-1:0] old_pd2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  rob_idx1,
  output logic [IDX_W-1:0]  rob_idx2,
  input  logic              cmp1_valid,
  input  logic              cmp2_valid,
  input  logic [IDX_W-1:0]  cmp1_idx,
  input  logic [IDX_W-1:0]  cmp2_idx,
  output logic              rt1valid,
  output logic              rt2valid,
  output logic [PREG_W-1:0] rt1reg,
  output logic [PREG_W-1:0] rt2reg,
  output logic [PC_W-1:0]   rt1pc,
  output logic [PC_W-1:0]   rt2pc,
  output logic [15:0]       retired_count
);

  rob_entry_t        entries_q [DEPTH];
  rob_entry_t        entries_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [15:0]       retired_count_q, retired_count_d;
  logic              rt1valid_q, rt1valid_d;
  logic              rt2valid_q, rt2valid_d;
  logic [PREG_W-1:0] rt1reg_q, rt1reg_d;
  logic [PREG_W-1:0] rt2reg_q, rt2reg_d;
  logic [PC_W-1:0]   rt1pc_q, rt1pc_d;
  logic [PC_W-1:0]   rt2pc_q, rt2pc_d;

  logic [IDX_W-1:0]  head_nx;
  logic [IDX_W-1:0]  tail_nx;
  logic [IDX_W-1:0]  slot2_idx;
  logic              acc1, acc2;
  logic              r0, r1;
  logic [1:0]        n_alloc;
  logic [1:0]        n_ret;

  assign head_nx   = head_q + IDX_W'(1);
  assign tail_nx   = tail_q + IDX_W'(1);
  assign slot2_idx = valid1 ? tail_nx : tail_q;

  // Registered count only: a retire in the same cycle does not free space early.
  assign alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - 2));
  assign acc1        = valid1 & alloc_ready;
  assign acc2        = valid2 & alloc_ready;

  assign r0 = entries_q[head_q].busy & entries_q[head_q].done;
  assign r1 = r0 & entries_q[head_nx].busy & entries_q[head_nx].done;

  assign n_alloc = {1'b0, acc1} + {1'b0, acc2};
  assign n_ret   = {1'b0, r0} + {1'b0, r1};

  always_comb begin
    entries_d = entries_q;

    // Completions land before the retire clear so a late duplicate report
    // against a retiring entry cannot leave a stale done bit behind.
    if (cmp1_valid && entries_q[cmp1_idx].busy) entries_d[cmp1_idx].done = 1'b1;
    if (cmp2_valid && entries_q[cmp2_idx].busy) entries_d[cmp2_idx].done = 1'b1;

    if (r0) begin
      entries_d[head_q].busy = 1'b0;
      entries_d[head_q].done = 1'b0;
    end
    if (r1) begin
      entries_d[head_nx].busy = 1'b0;
      entries_d[head_nx].done = 1'b0;
    end

    if (acc1) entries_d[tail_q] = '{busy: 1'b1, done: 1'b0, pc: pc1, pd: pd1, old_pd: old_pd1};
    if (acc2) entries_d[slot2_idx] = '{busy: 1'b1, done: 1'b0, pc: pc2, pd: pd2, old_pd: old_pd2};

    head_d          = head_q + IDX_W'(n_ret);
    tail_d          = tail_q + IDX_W'(n_alloc);
    count_d         = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
    retired_count_d = retired_count_q + 16'(n_ret);

    // Register 0 is architecturally pinned, so it is never handed back to rename.
    rt1valid_d = r0 && (entries_q[head_q].old_pd != '0);
    rt2valid_d = r1 && (entries_q[head_nx].old_pd != '0);
    rt1reg_d   = r0 ? entries_q[head_q].old_pd  : rt1reg_q;
    rt1pc_d    = r0 ? entries_q[head_q].pc      : rt1pc_q;
    rt2reg_d   = r1 ? entries_q[head_nx].old_pd : rt2reg_q;
    rt2pc_d    = r1 ? entries_q[head_nx].pc     : rt2pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      retired_count_q <= '0;
      rt1valid_q      <= 1'b0;
      rt2valid_q      <= 1'b0;
      rt1reg_q        <= '0;
      rt2reg_q        <= '0;
      rt1pc_q         <= '0;
      rt2pc_q         <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      retired_count_q <= retired_count_d;
      rt1valid_q      <= rt1valid_d;
      rt2valid_q      <= rt2valid_d;
      rt1reg_q        <= rt1reg_d;
      rt2reg_q        <= rt2reg_d;
      rt1pc_q         <= rt1pc_d;
      rt2pc_q         <= rt2pc_d;
    end
  end

  assign rob_idx1      = tail_q;
  assign rob_idx2      = slot2_idx;
  assign rt1valid      = rt1valid_q;
  assign rt2valid      = rt2valid_q;
  assign rt1reg        = rt1reg_q;
  assign rt2reg        = rt2reg_q;
  assign rt1pc         = rt1pc_q;
  assign rt2pc         = rt2pc_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed steps plus a random phase, checked against
// a program-order queue model of the buffer.
module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int D = 16;

  logic        clk, rst_n;
  logic        valid1, valid2;
  logic [7:0]  pc1, pc2;
  logic [5:0]  pd1, pd2, old_pd1, old_pd2;
  logic        alloc_ready;
  logic [3:0]  rob_idx1, rob_idx2;
  logic        cmp1_valid, cmp2_valid;
  logic [3:0]  cmp1_idx, cmp2_idx;
  logic        rt1valid, rt2valid;
  logic [5:0]  rt1reg, rt2reg;
  logic [7:0]  rt1pc, rt2pc;
  logic [15:0] retired_count;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .valid1(valid1), .valid2(valid2), .pc1(pc1), .pc2(pc2),
    .pd1(pd1), .pd2(pd2), .old_pd1(old_pd1), .old_pd2(old_pd2),
    .alloc_ready(alloc_ready), .rob_idx1(rob_idx1), .rob_idx2(rob_idx2),
    .cmp1_valid(cmp1_valid), .cmp2_valid(cmp2_valid),
    .cmp1_idx(cmp1_idx), .cmp2_idx(cmp2_idx),
    .rt1valid(rt1valid), .rt2valid(rt2valid), .rt1reg(rt1reg), .rt2reg(rt2reg),
    .rt1pc(rt1pc), .rt2pc(rt2pc), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int pc;
    int old_pd;
    bit done;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail, m_retired;
  int     e_rt1v, e_rt2v, e_rt1reg, e_rt2reg, e_rt1pc, e_rt2pc;
  int     got_pcs[$];
  int     exp_pcs[$];
  int     n_checks, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    valid1 = 0; valid2 = 0; pc1 = 0; pc2 = 0; pd1 = 0; pd2 = 0;
    old_pd1 = 0; old_pd2 = 0;
    cmp1_valid = 0; cmp2_valid = 0; cmp1_idx = 0; cmp2_idx = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_retired = 0;
    e_rt1v = 0; e_rt2v = 0; e_rt1reg = 0; e_rt2reg = 0; e_rt1pc = 0; e_rt2pc = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int  r;
    bit  ready;
    m_ent_t e;
    #1;
    ready = (mq.size() <= D - 2);
    chk("alloc_ready", alloc_ready, ready);
    chk("rob_idx1", rob_idx1, m_tail);
    chk("rob_idx2", rob_idx2, valid1 ? (m_tail + 1) % D : m_tail);
    @(posedge clk);
    r = 0;
    if (mq.size() > 0 && mq[0].done) r = 1;
    if (r == 1 && mq.size() > 1 && mq[1].done) r = 2;
    e_rt1v = 0; e_rt2v = 0;
    if (r >= 1) begin
      e_rt1v = (mq[0].old_pd != 0); e_rt1reg = mq[0].old_pd; e_rt1pc = mq[0].pc;
    end
    if (r == 2) begin
      e_rt2v = (mq[1].old_pd != 0); e_rt2reg = mq[1].old_pd; e_rt2pc = mq[1].pc;
    end
    foreach (mq[k])
      if ((cmp1_valid && mq[k].idx == int'(cmp1_idx)) || (cmp2_valid && mq[k].idx == int'(cmp2_idx)))
        mq[k].done = 1;
    repeat (r) mq.delete(0);
    m_retired = (m_retired + r) % 65536;
    if (ready) begin
      if (valid1) begin
        e = '{idx: m_tail, pc: int'(pc1), old_pd: int'(old_pd1), done: 0};
        mq.push_back(e); m_tail = (m_tail + 1) % D;
      end
      if (valid2) begin
        e = '{idx: m_tail, pc: int'(pc2), old_pd: int'(old_pd2), done: 0};
        mq.push_back(e); m_tail = (m_tail + 1) % D;
      end
    end
    #1;
    chk("rt1valid", rt1valid, e_rt1v);
    chk("rt2valid", rt2valid, e_rt2v);
    chk("rt1reg", rt1reg, e_rt1reg);
    chk("rt2reg", rt2reg, e_rt2reg);
    chk("rt1pc", rt1pc, e_rt1pc);
    chk("rt2pc", rt2pc, e_rt2pc);
    chk("retired_count", retired_count, m_retired);
    if (rt1valid === 1'b1) got_pcs.push_back(int'(rt1pc));
    if (rt2valid === 1'b1) got_pcs.push_back(int'(rt2pc));
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic alloc2(input int p1, input int o1, input int p2, input int o2);
    valid1 = 1; pc1 = 8'(p1); pd1 = 6'(32 + p1 % 32); old_pd1 = 6'(o1);
    valid2 = 1; pc2 = 8'(p2); pd2 = 6'(32 + p2 % 32); old_pd2 = 6'(o2);
  endtask

  task automatic drain();
    int ids[$];
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 40) begin
      ids.delete();
      foreach (mq[k]) if (!mq[k].done) ids.push_back(mq[k].idx);
      if (ids.size() > 0) begin cmp1_valid = 1; cmp1_idx = 4'(ids[0]); end
      if (ids.size() > 1) begin cmp2_valid = 1; cmp2_idx = 4'(ids[1]); end
      tick();
      guard++;
    end
    chk("drain_bound", mq.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    int t;
    n_checks = 0; n_err = 0;
    clear_inputs();
    model_reset();
    rst_n = 0;
    #12;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_rob_idx1", rob_idx1, 0);
    chk("rst_rt1valid", rt1valid, 0);
    chk("rst_rt2valid", rt2valid, 0);
    chk("rst_retired", retired_count, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // basic pair; second completes first, head holds retire back
    alloc2(0, 1, 4, 2); pd1 = 32; pd2 = 33;
    tick();
    cmp1_valid = 1; cmp1_idx = 1; tick();
    tick();
    cmp1_valid = 1; cmp1_idx = 0; tick();
    chk("t1_no_early_retire", rt1valid, 0);
    tick();
    chk("t1_rt1valid", rt1valid, 1);
    chk("t1_rt2valid", rt2valid, 1);
    chk("t1_rt1reg", rt1reg, 1);
    chk("t1_rt2reg", rt2reg, 2);
    chk("t1_retired", retired_count, 2);
    tick();
    chk("t1_pulse_len", rt1valid, 0);

    // fill: 14 entries keeps ready, the 15th drops it, then a pair is dropped
    for (int i = 0; i < 7; i++) begin
      alloc2(16 + 2 * i, 3 + i, 17 + 2 * i, 10 + i);
      tick();
    end
    chk("t2_ready_at_14", alloc_ready, 1);
    valid1 = 1; pc1 = 8'd40; old_pd1 = 6'd20; tick();
    chk("t2_ready_at_15", alloc_ready, 0);
    alloc2(50, 21, 51, 22); tick();
    chk("t2_tail_held", rob_idx1, 1);
    drain();
    chk("t2_retired", retired_count, 17);

    // old_pd of zero is never freed but still reported
    alloc2(60, 0, 64, 5); tick();
    cmp1_valid = 1; cmp1_idx = 1; cmp2_valid = 1; cmp2_idx = 2; tick();
    tick();
    chk("t3_rt1valid", rt1valid, 0);
    chk("t3_rt2valid", rt2valid, 1);
    chk("t3_rt2reg", rt2reg, 5);
    chk("t3_rt1reg", rt1reg, 0);
    chk("t3_retired", retired_count, 19);
    tick();

    // lone slot-2 request lands at tail
    valid2 = 1; pc2 = 8'd8; old_pd2 = 6'd9;
    #1;
    chk("t4_idx2_is_tail", rob_idx2, 3);
    tick();
    chk("t4_tail_plus1", rob_idx1, 4);
    drain();
    chk("t4_retired", retired_count, 20);

    // 40 instructions, reverse-order completion per pair, pointers wrap twice
    got_pcs.delete(); exp_pcs.delete();
    for (int i = 0; i < 20; i++) begin
      t = m_tail;
      alloc2(100 + 2 * i, 1 + (2 * i) % 60, 101 + 2 * i, 1 + (2 * i + 1) % 60);
      exp_pcs.push_back(100 + 2 * i); exp_pcs.push_back(101 + 2 * i);
      tick();
      cmp1_valid = 1; cmp1_idx = 4'((t + 1) % D); tick();
      cmp1_valid = 1; cmp1_idx = 4'(t); tick();
    end
    repeat (3) tick();
    chk("t5_retire_n", got_pcs.size(), 40);
    for (int i = 0; i < 40 && i < got_pcs.size(); i++)
      chk("t5_order", got_pcs[i], exp_pcs[i]);
    chk("t5_retired", retired_count, 60);
    chk("t5_empty_ready", alloc_ready, 1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) < 7) begin
        valid1 = 1; pc1 = 8'($urandom); pd1 = 6'($urandom);
        old_pd1 = ($urandom_range(5) == 0) ? 6'd0 : 6'($urandom);
      end
      if ($urandom_range(9) < 6) begin
        valid2 = 1; pc2 = 8'($urandom); pd2 = 6'($urandom);
        old_pd2 = ($urandom_range(5) == 0) ? 6'd0 : 6'($urandom);
      end
      if ($urandom_range(9) < 7) begin
        cmp1_valid = 1;
        cmp1_idx = (mq.size() > 0 && $urandom_range(3) != 0)
                   ? 4'(mq[$urandom_range(mq.size() - 1)].idx) : 4'($urandom);
      end
      if ($urandom_range(9) < 5) begin
        cmp2_valid = 1;
        cmp2_idx = (mq.size() > 0 && $urandom_range(3) != 0)
                   ? 4'(mq[$urandom_range(mq.size() - 1)].idx) : 4'($urandom);
      end
      tick();
    end
    drain();

    // reset with 6 busy entries, head pair already done
    t = m_tail;
    for (int i = 0; i < 3; i++) begin
      alloc2(200 + 2 * i, 7, 201 + 2 * i, 8);
      tick();
    end
    cmp1_valid = 1; cmp1_idx = 4'(t); cmp2_valid = 1; cmp2_idx = 4'((t + 1) % D);
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("t7_rst_ready", alloc_ready, 1);
    chk("t7_rst_idx1", rob_idx1, 0);
    chk("t7_rst_idx2", rob_idx2, 0);
    chk("t7_rst_rt1valid", rt1valid, 0);
    chk("t7_rst_rt2valid", rt2valid, 0);
    chk("t7_rst_rt1reg", rt1reg, 0);
    chk("t7_rst_rt1pc", rt1pc, 0);
    chk("t7_rst_retired", retired_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();
    valid1 = 1; pc1 = 8'd12; old_pd1 = 6'd3;
    #1;
    chk("t7_first_idx", rob_idx1, 0);
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
